// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
//   Second stage of the RV32I pipeline. Decodes a fetched {pc, instr} pair
//   into register indices, a sign-extended immediate, an ALU opcode and an
//   operation class, and hands the result to execute over a valid/ready
//   interface. A main register plus a one-entry skid register let in_ready be
//   a flop, so execute backpressure never reaches fetch combinationally.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   in_valid        fetch presents an instruction
//   in_ready        stage accepts this cycle (registered)
//   in_pc/in_instr  instruction address / raw word
//   flush           drop everything buffered and anything arriving now
//   out_valid       decoded instruction presented to execute
//   out_ready       execute accepts
//   out_pc          pc of the presented instruction
//   out_rd/rs1/rs2  register indices, 0 when the format has no such field
//   out_imm         sign-extended immediate, 0 for R-type
//   out_use_imm     ALU operand B is out_imm instead of rs2
//   out_alu_op      0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA
//                   8 OR 9 AND 10 PASS_B
//   out_class       0 ALU 1 LOAD 2 STORE 3 BRANCH 4 JAL 5 JALR 6 UPPER
//                   7 SYSTEM
//   out_funct3      instr[14:12] passthrough
//   out_illegal     not a legal RV32I encoding
// ----------------------------------------------------------------------------
module decode_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic            out_use_imm,
    output logic [3:0]      out_alu_op,
    output logic [2:0]      out_class,
    output logic [2:0]      out_funct3,
    output logic            out_illegal
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned ALU_W = 4;
    localparam int unsigned CLS_W = 3;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned F7_W  = 7;

    // Buffer occupancy: bit 1 = main register valid, bit 0 = skid valid
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL1 = 2'b10;
    localparam logic [1:0] ST_FULL2 = 2'b11;

    localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
    localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

    localparam logic [ALU_W-1:0] ALU_ADD    = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB    = 4'd1;
    localparam logic [ALU_W-1:0] ALU_SLL    = 4'd2;
    localparam logic [ALU_W-1:0] ALU_SLT    = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SLTU   = 4'd4;
    localparam logic [ALU_W-1:0] ALU_XOR    = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SRL    = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SRA    = 4'd7;
    localparam logic [ALU_W-1:0] ALU_OR     = 4'd8;
    localparam logic [ALU_W-1:0] ALU_AND    = 4'd9;
    localparam logic [ALU_W-1:0] ALU_PASS_B = 4'd10;

    localparam logic [CLS_W-1:0] CLS_ALU    = 3'd0;
    localparam logic [CLS_W-1:0] CLS_LOAD   = 3'd1;
    localparam logic [CLS_W-1:0] CLS_STORE  = 3'd2;
    localparam logic [CLS_W-1:0] CLS_BRANCH = 3'd3;
    localparam logic [CLS_W-1:0] CLS_JAL    = 3'd4;
    localparam logic [CLS_W-1:0] CLS_JALR   = 3'd5;
    localparam logic [CLS_W-1:0] CLS_UPPER  = 3'd6;
    localparam logic [CLS_W-1:0] CLS_SYSTEM = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
        logic             use_imm;
        logic [ALU_W-1:0] alu_op;
        logic [CLS_W-1:0] cls;
        logic [F3_W-1:0]  funct3;
        logic             illegal;
    } dec_t;

    // Shared funct3 -> ALU op map for OP and OP-IMM; alt selects SUB/SRA
    function automatic logic [ALU_W-1:0] alu_from_funct3(input logic [F3_W-1:0] f3,
                                                         input logic            alt);
        logic [ALU_W-1:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Instruction fields
    logic [OPC_W-1:0] w_opcode;
    logic [REG_W-1:0] w_rd;
    logic [REG_W-1:0] w_rs1;
    logic [REG_W-1:0] w_rs2;
    logic [F3_W-1:0]  w_funct3;
    logic [F7_W-1:0]  w_funct7;

    assign w_opcode = in_instr[6:0];
    assign w_rd     = in_instr[11:7];
    assign w_funct3 = in_instr[14:12];
    assign w_rs1    = in_instr[19:15];
    assign w_rs2    = in_instr[24:20];
    assign w_funct7 = in_instr[31:25];

    // Immediates, all sign-extended from instr[31]
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;

    assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u = {in_instr[31:12], 12'b0};
    assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};

    // Combinational decode of the incoming word
    dec_t w_dec;
    logic w_legal;

    always_comb begin
        w_dec        = '0;
        w_dec.pc     = in_pc;
        w_dec.funct3 = w_funct3;
        w_dec.alu_op = ALU_ADD;
        w_dec.cls    = CLS_ALU;
        w_legal      = 1'b1;
        case (w_opcode)
            OPC_OP: begin
                w_dec.rd     = w_rd;
                w_dec.rs1    = w_rs1;
                w_dec.rs2    = w_rs2;
                w_dec.alu_op = alu_from_funct3(w_funct3, w_funct7[5]);
                w_legal      = (w_funct7 == F7_BASE) ||
                               ((w_funct7 == F7_ALT) &&
                                ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                w_dec.rd      = w_rd;
                w_dec.rs1     = w_rs1;
                w_dec.imm     = w_imm_i;
                w_dec.use_imm = 1'b1;
                // Only the right shift has an alternate form; there is no SUBI
                w_dec.alu_op  = alu_from_funct3(w_funct3,
                                                (w_funct3 == 3'b101) && w_funct7[5]);
                if (w_funct3 == 3'b001) begin
                    w_legal = (w_funct7 == F7_BASE);
                end else if (w_funct3 == 3'b101) begin
                    w_legal = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
                end
            end
            OPC_LOAD: begin
                w_dec.rd      = w_rd;
                w_dec.rs1     = w_rs1;
                w_dec.imm     = w_imm_i;
                w_dec.use_imm = 1'b1;
                w_dec.cls     = CLS_LOAD;
                w_legal       = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) &&
                                (w_funct3 != 3'b111);
            end
            OPC_STORE: begin
                w_dec.rs1     = w_rs1;
                w_dec.rs2     = w_rs2;
                w_dec.imm     = w_imm_s;
                w_dec.use_imm = 1'b1;
                w_dec.cls     = CLS_STORE;
                w_legal       = !w_funct3[2] && (w_funct3[1:0] != 2'b11);
            end
            OPC_BRANCH: begin
                w_dec.rs1 = w_rs1;
                w_dec.rs2 = w_rs2;
                w_dec.imm = w_imm_b;
                w_dec.cls = CLS_BRANCH;
                // funct3[2:1]: 00 EQ/NE, 10 LT/GE, 11 LTU/GEU, 01 reserved
                case (w_funct3[2:1])
                    2'b10:   w_dec.alu_op = ALU_SLT;
                    2'b11:   w_dec.alu_op = ALU_SLTU;
                    default: w_dec.alu_op = ALU_SUB;
                endcase
                w_legal = (w_funct3[2:1] != 2'b01);
            end
            OPC_JAL: begin
                w_dec.rd      = w_rd;
                w_dec.imm     = w_imm_j;
                w_dec.use_imm = 1'b1;
                w_dec.cls     = CLS_JAL;
            end
            OPC_JALR: begin
                w_dec.rd      = w_rd;
                w_dec.rs1     = w_rs1;
                w_dec.imm     = w_imm_i;
                w_dec.use_imm = 1'b1;
                w_dec.cls     = CLS_JALR;
                w_legal       = (w_funct3 == 3'b000);
            end
            OPC_LUI: begin
                w_dec.rd      = w_rd;
                w_dec.imm     = w_imm_u;
                w_dec.use_imm = 1'b1;
                w_dec.alu_op  = ALU_PASS_B;
                w_dec.cls     = CLS_UPPER;
            end
            OPC_AUIPC: begin
                w_dec.rd      = w_rd;
                w_dec.imm     = w_imm_u;
                w_dec.use_imm = 1'b1;
                w_dec.cls     = CLS_UPPER;
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                w_dec.rd      = w_rd;
                w_dec.rs1     = w_rs1;
                w_dec.imm     = w_imm_i;
                w_dec.use_imm = 1'b1;
                w_dec.cls     = CLS_SYSTEM;
            end
            default: begin
                // Unlisted opcodes, including instr[1:0] != 11 and all-zero
                w_legal = 1'b0;
            end
        endcase
        // Illegal words travel as an inert SYSTEM op that writes nothing
        if (!w_legal) begin
            w_dec         = '0;
            w_dec.pc      = in_pc;
            w_dec.funct3  = w_funct3;
            w_dec.cls     = CLS_SYSTEM;
            w_dec.illegal = 1'b1;
        end
    end

    // Buffer control
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_in_ready;
    dec_t       r_main;
    dec_t       r_skid;
    logic       w_in_xfer;
    logic       w_out_xfer;
    logic       w_load_main_in;
    logic       w_load_main_skid;
    logic       w_load_skid;

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_state[1] && out_ready;

    // Next occupancy and register load strobes
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt    = ST_FULL1;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_FULL1: begin
                    if (w_out_xfer && w_in_xfer) begin
                        w_load_main_in = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_nxt = ST_EMPTY;
                    end else if (w_in_xfer) begin
                        w_state_nxt = ST_FULL2;
                        w_load_skid = 1'b1;
                    end
                end
                ST_FULL2: begin
                    if (w_out_xfer) begin
                        w_state_nxt      = ST_FULL1;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State register; in_ready is the registered complement of next skid valid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= !w_state_nxt[0];
        end
    end

    // Main and skid payload registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= w_dec;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_state[1];
    assign out_pc      = r_main.pc;
    assign out_rd      = r_main.rd;
    assign out_rs1     = r_main.rs1;
    assign out_rs2     = r_main.rs2;
    assign out_imm     = r_main.imm;
    assign out_use_imm = r_main.use_imm;
    assign out_alu_op  = r_main.alu_op;
    assign out_class   = r_main.cls;
    assign out_funct3  = r_main.funct3;
    assign out_illegal = r_main.illegal;

endmodule
